// File: rtl/tlight_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlight_pkg
// Brief    : Shared lamp encodings and phase enumeration for the traffic
//            light controller.
// Revision : 1.0 - initial release
// ============================================================================
package tlight_pkg;

  localparam logic [2:0] LIG_RED    = 3'b100;
  localparam logic [2:0] LIG_GREEN  = 3'b010;
  localparam logic [2:0] LIG_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    PH_CLEAR  = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/tlight_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : tlight_dwell_timer
// Brief    : Tick-gated down counter. Loads a dwell value, counts down on
//            tick, and flags the tick on which the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
module tlight_dwell_timer #(
  parameter int          CW      = 16,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          done
);

  // The phase ends on the tick that finds the count already at zero.
  assign done = tick & (cnt == '0);

  // Load has priority so a new phase starts with its full dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlight_ctrl
// Brief    : Round-robin multi-approach traffic light controller with
//            green/yellow/all-red service per approach and an all-red
//            pedestrian WALK phase granted at the end of a clearance.
// Revision : 1.0 - initial release
// ============================================================================
module tlight_ctrl
  import tlight_pkg::*;
#(
  parameter int N_DIR    = 4,
  parameter int CW       = 16,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 4,
  parameter int T_CLEAR  = 2,
  parameter int T_WALK   = 10,
  localparam int DW      = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               ped_req,
  output logic [3*N_DIR-1:0] lig,
  output logic               walk,
  output logic               ped_pending,
  output logic [1:0]         phase,
  output logic [DW-1:0]      cur_dir
);

  localparam logic [CW-1:0] C_LD_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] C_LD_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] C_LD_CLEAR  = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] C_LD_WALK   = CW'(T_WALK - 1);
  localparam logic [DW-1:0] C_LAST_DIR  = DW'(N_DIR - 1);

  phase_e          state;
  phase_e          nxt_state;
  logic [DW-1:0]   nxt_dir;
  logic [CW-1:0]   load_val;
  logic [CW-1:0]   dwell_cnt;
  logic            done;
  logic            advance;
  logic            grant_walk;
  logic [3*N_DIR-1:0] nxt_lig;

  tlight_dwell_timer #(
    .CW      (CW),
    .RST_VAL (C_LD_CLEAR)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (advance),
    .load_val (load_val),
    .cnt      (dwell_cnt),
    .done     (done)
  );

  assign advance    = done & (dwell_cnt == '0);
  assign grant_walk = advance & (state == PH_CLEAR) & ped_pending;

  // Next phase, next approach and the dwell to load when the phase ends.
  always_comb begin
    nxt_state = state;
    nxt_dir   = cur_dir;
    if (advance) begin
      case (state)
        PH_CLEAR:  nxt_state = ped_pending ? PH_WALK : PH_GREEN;
        PH_GREEN:  nxt_state = PH_YELLOW;
        PH_YELLOW: begin
          nxt_state = PH_CLEAR;
          nxt_dir   = (cur_dir == C_LAST_DIR) ? '0 : cur_dir + 1'b1;
        end
        default:   nxt_state = PH_GREEN;
      endcase
    end
    case (nxt_state)
      PH_GREEN:  load_val = C_LD_GREEN;
      PH_YELLOW: load_val = C_LD_YELLOW;
      PH_WALK:   load_val = C_LD_WALK;
      default:   load_val = C_LD_CLEAR;
    endcase
  end

  // Lamp field for the upcoming state: only the served approach may be non-red.
  always_comb begin
    nxt_lig = {N_DIR{LIG_RED}};
    for (int i = 0; i < N_DIR; i++) begin
      if (DW'(i) == nxt_dir) begin
        if (nxt_state == PH_GREEN) begin
          nxt_lig[3*i +: 3] = LIG_GREEN;
        end else if (nxt_state == PH_YELLOW) begin
          nxt_lig[3*i +: 3] = LIG_YELLOW;
        end
      end
    end
  end

  // Controller state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PH_CLEAR;
      cur_dir     <= '0;
      lig         <= {N_DIR{LIG_RED}};
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state   <= nxt_state;
      cur_dir <= nxt_dir;
      lig     <= nxt_lig;
      walk    <= (nxt_state == PH_WALK);
      // Granting the walk consumes the request, including one arriving on that edge.
      if (grant_walk) begin
        ped_pending <= 1'b0;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
    end
  end

  assign phase = state;

endmodule
`default_nettype wire

// File: tb/tb_tlight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlight_ctrl
// Brief    : Self-checking bench for tlight_ctrl with a tick-level reference
//            model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlight_ctrl;

  localparam int N_DIR    = 3;
  localparam int CW       = 16;
  localparam int T_GREEN  = 4;
  localparam int T_YELLOW = 2;
  localparam int T_CLEAR  = 1;
  localparam int T_WALK   = 3;
  localparam int DW       = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic               ped_req;
  logic [3*N_DIR-1:0] lig;
  logic               walk;
  logic               ped_pending;
  logic [1:0]         phase;
  logic [DW-1:0]      cur_dir;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number, ticks remaining, approach, pending flag.
  int m_phase;
  int m_rem;
  int m_dir;
  bit m_pend;

  always #5 clk = ~clk;

  tlight_ctrl #(
    .N_DIR    (N_DIR),
    .CW       (CW),
    .T_GREEN  (T_GREEN),
    .T_YELLOW (T_YELLOW),
    .T_CLEAR  (T_CLEAR),
    .T_WALK   (T_WALK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
    .lig         (lig),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase),
    .cur_dir     (cur_dir)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3*N_DIR-1:0] exp_lig();
    logic [3*N_DIR-1:0] v;
    for (int i = 0; i < N_DIR; i++) begin
      v[3*i +: 3] = 3'b100;
      if (i == m_dir && m_phase == 1) v[3*i +: 3] = 3'b010;
      if (i == m_dir && m_phase == 2) v[3*i +: 3] = 3'b001;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_rem   = T_CLEAR;
    m_dir   = 0;
    m_pend  = 1'b0;
  endtask

  // One clock edge of the intersection: a phase lasts exactly its dwell in ticks.
  task automatic model_edge(input bit tk, input bit pr);
    bit granted = 1'b0;
    if (tk) begin
      if (m_rem > 1) begin
        m_rem--;
      end else begin
        case (m_phase)
          0: if (m_pend) begin m_phase = 3; m_rem = T_WALK; granted = 1'b1; end
             else        begin m_phase = 1; m_rem = T_GREEN; end
          1: begin m_phase = 2; m_rem = T_YELLOW; end
          2: begin m_phase = 0; m_rem = T_CLEAR; m_dir = (m_dir + 1) % N_DIR; end
          default: begin m_phase = 1; m_rem = T_GREEN; end
        endcase
      end
    end
    if (granted) m_pend = 1'b0;
    else if (pr) m_pend = 1'b1;
  endtask

  task automatic check_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("cur_dir", 32'(cur_dir), 32'(m_dir));
    chk("lig", 32'(lig), 32'(exp_lig()));
    chk("walk", 32'(walk), 32'(m_phase == 3));
    chk("ped_pending", 32'(ped_pending), 32'(m_pend));
  endtask

  task automatic step(input bit tk, input bit pr);
    tick    = tk;
    ped_req = pr;
    @(posedge clk);
    model_edge(tk, pr);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, held over one edge, released mid-cycle.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick    = 1'b1;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("rst_lig_lit", 32'(lig), 32'h124);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic sequence and one full rotation.
    step(1, 0);
    chk("g0_phase_lit", 32'(phase), 32'd1);
    chk("g0_lig_lit", 32'(lig), 32'(9'b100_100_010));
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("y0_lig_lit", 32'(lig), 32'(9'b100_100_001));
    step(1, 0);
    step(1, 0);
    chk("c1_phase_lit", 32'(phase), 32'd0);
    chk("c1_dir_lit", 32'(cur_dir), 32'd1);
    for (int i = 0; i < 14; i++) step(1, 0);
    chk("wrap_dir_lit", 32'(cur_dir), 32'd0);
    chk("wrap_lig_lit", 32'(lig), 32'(9'b100_100_100));

    // Pedestrian pulse during green dir0.
    step(1, 0);
    step(1, 1);
    chk("ped_set_lit", 32'(ped_pending), 32'd1);
    step(1, 0);
    step(1, 0);
    chk("green_full_lit", 32'(phase), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("walk_lit", 32'(walk), 32'd1);
    chk("walk_lig_lit", 32'(lig), 32'(9'b100_100_100));
    chk("walk_pend_lit", 32'(ped_pending), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0);
    chk("after_walk_phase_lit", 32'(phase), 32'd1);
    chk("after_walk_dir_lit", 32'(cur_dir), 32'd1);

    // Tick gating: one tick every third cycle.
    for (int i = 0; i < 60; i++) step((i % 3) == 0, 0);

    // Async reset mid-yellow on dir1.
    n = 0;
    while (!(m_phase == 2 && m_dir == 1) && n < 100) begin step(1, 0); n++; end
    chk("reach_y1", 32'(n < 100), 32'd1);
    async_reset();
    chk("rst_dir_lit", 32'(cur_dir), 32'd0);
    step(1, 0);
    chk("post_rst_phase_lit", 32'(phase), 32'd1);
    chk("post_rst_dir_lit", 32'(cur_dir), 32'd0);

    // Request held through the grant edge, then re-pulsed during walk.
    n = 0;
    while (m_phase != 3 && n < 50) begin step(1, 1); n++; end
    chk("reach_walk", 32'(n < 50), 32'd1);
    chk("absorb_lit", 32'(ped_pending), 32'd0);
    step(1, 0);
    step(1, 1);
    chk("repulse_lit", 32'(ped_pending), 32'd1);
    n = 0;
    while (m_phase == 3 && n < 10) begin step(1, 0); n++; end
    while (m_phase != 3 && n < 50) begin step(1, 0); n++; end
    chk("second_walk_lit", 32'(walk), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else step($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlight_ctrl.md
Name: tlight_ctrl

Overview:
- Parametrised multi-approach traffic light controller. Successor to the fixed 3-state single-light sequencer.
- Serves N_DIR approaches round-robin. Each service is green, then yellow, then all-red clearance.
- Per-phase dwell times are parameters. Time advances on an external tick enable.
- A latched pedestrian request inserts an all-red WALK phase.
- Sits at the top of the intersection design and drives lamp drivers directly.

Parameters:
- N_DIR, 4, number of approaches (2..8).
- CW, 16, dwell counter width.
- T_GREEN, 20, green dwell in ticks (1..2^CW-1).
- T_YELLOW, 4, yellow dwell in ticks (1..2^CW-1).
- T_CLEAR, 2, all-red clearance dwell in ticks (1..2^CW-1).
- T_WALK, 10, pedestrian walk dwell in ticks (1..2^CW-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  time-base enable; dwell counters advance only when tick=1.
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk.
- lig  out  3*N_DIR  lamp field per approach; lig[3*i+:3] is approach i. Encoding: 3'b100 red, 3'b010 green, 3'b001 yellow.
- walk  out  1  walk signal, high only in WALK.
- ped_pending  out  1  pedestrian request latched and not yet served.
- phase  out  2  current state: 0 CLEAR, 1 GREEN, 2 YELLOW, 3 WALK.
- cur_dir  out  DW  approach currently served; DW = max(1, clog2(N_DIR)).

Behaviour:
- All outputs are registered and change only on clk rising edge or rst.
- Reset values while rst=1:
  - phase=CLEAR, cur_dir=0, cnt=T_CLEAR-1.
  - All lig fields = 3'b100.
  - walk=0, ped_pending=0.
- Reset mid-phase aborts immediately to the reset state (all red). No partial yellow is completed.
- Dwell rule:
  - On entering any phase, cnt loads T_phase-1.
  - In a cycle with tick=1: if cnt==0 the phase transitions, else cnt decrements.
  - tick=0 freezes state, cnt and outputs.
  - Each phase therefore lasts exactly T_phase ticks; with tick held high, T_phase clk cycles.
- Transitions, all taken on a tick=1 cycle with cnt==0:
  - CLEAR -> WALK if ped_pending=1, else GREEN.
  - GREEN -> YELLOW.
  - YELLOW -> CLEAR, with cur_dir <= cur_dir+1, wrapping N_DIR-1 -> 0. Non-power-of-two N_DIR must wrap correctly.
  - WALK -> GREEN. cur_dir is unchanged, so the approach waiting before the walk is served next.
- Lamp outputs:
  - GREEN: approach cur_dir = 3'b010; all others 3'b100.
  - YELLOW: approach cur_dir = 3'b001; all others 3'b100.
  - CLEAR and WALK: all approaches 3'b100.
- At most one field is ever non-red. Green is never followed directly by another approach's green.
- walk=1 exactly while phase=WALK.
- ped_pending:
  - Set on any cycle with ped_req=1, independent of tick.
  - Cleared on the CLEAR->WALK transition edge.
  - ped_req=1 on that same edge is absorbed (pending ends 0).
  - ped_req during WALK sets pending again, to be served after the next clearance.
- Pedestrian service never shortens an in-progress green or yellow. It is only granted at the end of a clearance.

Decomposition:
- Shared package tlight_pkg holds:
  - Lamp constants LIG_RED=3'b100, LIG_GREEN=3'b010, LIG_YELLOW=3'b001.
  - Phase enum CLEAR/GREEN/YELLOW/WALK (2 bits).
- One natural sub-module: tlight_dwell_timer.
  - Parameter CW; inputs clk, rst, tick, load, load_val.
  - Outputs cnt and done, where done = tick & (cnt==0).
  - The FSM, the direction counter and lamp decoding stay in tlight_ctrl.

Test Plan:
- Bench parameters for all scenarios: N_DIR=3, T_GREEN=4, T_YELLOW=2, T_CLEAR=1, T_WALK=3, tick=1 unless stated.
- Release rst, no ped_req -> cycles 0..6 phase sequence CLEAR(1), GREEN(4), YELLOW(2), then CLEAR with cur_dir=1. lig = 100_100_010 during GREEN dir0 (approach 0 in the low field). Full rotation is 21 cycles, ending back at dir0.
- Wrap: run until cur_dir=2 -> after YELLOW dir2 ends, cur_dir=0 and lig all 3'b100 for 1 cycle.
- Pulse ped_req 1 cycle during GREEN dir0 -> ped_pending=1 immediately; green still lasts 4 cycles. After yellow and clear: walk=1 for 3 cycles with all lamps red, ped_pending=0, then GREEN on dir1.
- Tick gating: tick=1 every 3rd cycle -> GREEN lasts 12 clk cycles, yellow 6; state and outputs are constant on tick=0 cycles.
- Assert rst asynchronously mid-YELLOW dir1 (between clk edges) -> lig all 3'b100, phase=0, cur_dir=0, walk=0, ped_pending=0 before the next clk edge. After release, the 1-cycle CLEAR is followed by GREEN on dir0.
- ped_req held high through the CLEAR->WALK edge and released in WALK -> ped_pending=0 after the edge. Re-pulse in WALK -> ped_pending=1 and a second WALK after the next yellow and clear.
